// File: rtl/cavlc_stage_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cavlc_stage_sequencer                                         |
// | Purpose  : Sequences the CAVLC residual stages and muxes their shifts.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cavlc_stage_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Start,
  input  logic [4:0] MaxNumCoeff,
  input  logic [4:0] TokTotalCoeff,
  input  logic [1:0] TokTrailingOnes,
  input  logic [3:0] TzTotalZeros,
  input  logic       TokDone,
  input  logic       LvlDone,
  input  logic       TzDone,
  input  logic       RbDone,
  input  logic       TokShiftEn,
  input  logic       LvlShiftEn,
  input  logic       TzShiftEn,
  input  logic       RbShiftEn,
  input  logic [4:0] TokNumShift,
  input  logic [4:0] LvlNumShift,
  input  logic [4:0] TzNumShift,
  input  logic [4:0] RbNumShift,
  output logic       TokEn,
  output logic       LvlEn,
  output logic       TzEn,
  output logic       RbEn,
  output logic       ShiftEn,
  output logic [4:0] NumShift,
  output logic [4:0] TotalCoeff,
  output logic [1:0] TrailingOnes,
  output logic [3:0] TotalZeros,
  output logic       Busy,
  output logic       BlockDone,
  output logic       Error
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_TOKEN = 3'd1;
  localparam logic [2:0] c_LEVEL = 3'd2;
  localparam logic [2:0] c_ZEROS = 3'd3;
  localparam logic [2:0] c_RUN   = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] c_TIMEOUT = TIMEOUT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       r_state;
  logic [2:0]       w_nextState;
  logic [4:0]       r_maxNumCoeff;
  logic [4:0]       r_totalCoeff;
  logic [1:0]       r_trailingOnes;
  logic [3:0]       r_totalZeros;
  logic [CNT_W-1:0] r_cnt;
  logic             r_errFlag;
  logic             w_active;
  logic             w_stageDone;
  logic             w_expired;
  logic             w_accept;

  assign w_accept = (r_state == c_IDLE) && Start;
  assign w_active = (r_state == c_TOKEN) || (r_state == c_LEVEL) ||
                    (r_state == c_ZEROS) || (r_state == c_RUN);

  // Only the enabled stage's Done counts; a Done in the expiry cycle wins.
  assign w_stageDone = ((r_state == c_TOKEN) && TokDone) ||
                       ((r_state == c_LEVEL) && LvlDone) ||
                       ((r_state == c_ZEROS) && TzDone)  ||
                       ((r_state == c_RUN)   && RbDone);
  assign w_expired   = w_active && (r_cnt >= c_TIMEOUT) && !w_stageDone;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_IDLE:  if (Start) w_nextState = c_TOKEN;
      c_TOKEN: if (TokDone) w_nextState = (TokTotalCoeff == 5'd0) ? c_DONE : c_LEVEL;
      c_LEVEL: if (LvlDone) w_nextState = (r_totalCoeff == r_maxNumCoeff) ? c_DONE : c_ZEROS;
      c_ZEROS: if (TzDone) w_nextState = ((TzTotalZeros != 4'd0) && (r_totalCoeff > 5'd1)) ?
                                         c_RUN : c_DONE;
      c_RUN:   if (RbDone) w_nextState = c_DONE;
      c_DONE:  w_nextState = c_IDLE;
      default: w_nextState = c_IDLE;
    endcase
    if (w_expired) w_nextState = c_DONE;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state        <= c_IDLE;
      r_maxNumCoeff  <= 5'd0;
      r_totalCoeff   <= 5'd0;
      r_trailingOnes <= 2'd0;
      r_totalZeros   <= 4'd0;
      r_cnt          <= {CNT_W{1'b0}};
      r_errFlag      <= 1'b0;
    end else begin
      r_state <= w_nextState;

      if (w_accept) begin
        r_maxNumCoeff <= MaxNumCoeff;
        r_totalZeros  <= 4'd0;
      end else if ((r_state == c_ZEROS) && TzDone) begin
        r_totalZeros  <= TzTotalZeros;
      end

      if ((r_state == c_TOKEN) && TokDone) begin
        r_totalCoeff   <= TokTotalCoeff;
        r_trailingOnes <= TokTrailingOnes;
      end

      if (w_accept) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (w_active && (r_cnt != c_CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_expired) begin
        r_errFlag <= 1'b1;
      end else if (r_state == c_DONE) begin
        r_errFlag <= 1'b0;
      end
    end
  end

  assign TokEn     = (r_state == c_TOKEN);
  assign LvlEn     = (r_state == c_LEVEL);
  assign TzEn      = (r_state == c_ZEROS);
  assign RbEn      = (r_state == c_RUN);
  assign Busy      = (r_state != c_IDLE);
  assign BlockDone = (r_state == c_DONE);
  assign Error     = (r_state == c_DONE) && r_errFlag;

  assign TotalCoeff   = r_totalCoeff;
  assign TrailingOnes = r_trailingOnes;
  assign TotalZeros   = r_totalZeros;

  always_comb begin
    ShiftEn  = 1'b0;
    NumShift = 5'd0;
    case (r_state)
      c_TOKEN: begin ShiftEn = TokShiftEn; NumShift = TokNumShift; end
      c_LEVEL: begin ShiftEn = LvlShiftEn; NumShift = LvlNumShift; end
      c_ZEROS: begin ShiftEn = TzShiftEn;  NumShift = TzNumShift;  end
      c_RUN:   begin ShiftEn = RbShiftEn;  NumShift = RbNumShift;  end
      default: begin ShiftEn = 1'b0;       NumShift = 5'd0;        end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/cavlc_stage_sequencer.md
# cavlc_stage_sequencer

Top-level controller for one CAVLC residual-block decode. It enables the coeff_token, level, total_zeros and run_before stages in bitstream order, skips stages the syntax makes unnecessary, and owns the single shared barrel shifter by muxing each stage's shift request onto it. It captures TotalCoeff/TrailingOnes/TotalZeros for the downstream stages and signals block completion or timeout to the slice-level parser.

## Interface
Parameters:
- TIMEOUT, 255, maximum cycles from Start to block completion before Error is raised.
- CNT_W, 8, width of the watchdog counter; TIMEOUT must be < 2**CNT_W.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- nReset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request to decode one block; ignored unless in IDLE.
- MaxNumCoeff  input  5  sampled on accepted Start; 16, 15 or 4.
- TokTotalCoeff  input  5  from coeff_token stage, valid when TokDone.
- TokTrailingOnes  input  2  from coeff_token stage, valid when TokDone.
- TzTotalZeros  input  4  from total_zeros stage, valid when TzDone.
- TokDone, LvlDone, TzDone, RbDone  input  1 each  stage done (combinational in stage, sampled here).
- TokShiftEn, LvlShiftEn, TzShiftEn, RbShiftEn  input  1 each  stage shift requests.
- TokNumShift, LvlNumShift, TzNumShift, RbNumShift  input  5 each  stage shift amounts.
- TokEn, LvlEn, TzEn, RbEn  output  1 each  stage enables.
- ShiftEn  output  1  to barrel shifter.
- NumShift  output  5  to barrel shifter.
- TotalCoeff  output  5  latched TokTotalCoeff.
- TrailingOnes  output  2  latched TokTrailingOnes.
- TotalZeros  output  4  latched TzTotalZeros; 0 if ZEROS is skipped.
- Busy  output  1  high in every state except IDLE.
- BlockDone  output  1  one-cycle pulse at block end.
- Error  output  1  one-cycle pulse with BlockDone when the watchdog expired.

## Operation
- States: IDLE, TOKEN, LEVEL, ZEROS, RUN, DONE. Moore enables: TokEn=TOKEN, LvlEn=LEVEL, TzEn=ZEROS, RbEn=RUN.
- IDLE -> TOKEN on Start. MaxNumCoeff is latched and the watchdog is cleared at the same edge.
- TOKEN on TokDone: latch TotalCoeff and TrailingOnes. If TokTotalCoeff==0, go to DONE. Otherwise go to LEVEL.
- LEVEL on LvlDone: if TotalCoeff==MaxNumCoeff, go to DONE with TotalZeros=0. Otherwise go to ZEROS.
- ZEROS on TzDone: latch TotalZeros. If TzTotalZeros!=0 and TotalCoeff>1, go to RUN. Otherwise go to DONE.
- RUN on RbDone: go to DONE.
- DONE: BlockDone=1 for one cycle, then IDLE unconditionally. All enables are low in DONE, which gives every stage at least one disabled cycle between blocks so its counters clear.
- Shifter mux (combinational): ShiftEn/NumShift come from the stage whose enable is high. In IDLE and DONE, ShiftEn=0 and NumShift=0. Requests from non-enabled stages are ignored.
- Watchdog: increments each cycle in TOKEN..RUN and saturates at 2**CNT_W-1. When it reaches TIMEOUT and no Done is present: force DONE and set an internal error flag. In DONE, Error=flag, then the flag clears.
- Start while Busy is dropped and not queued. Done inputs from a non-enabled stage are ignored.

## Timing
- Reset: state=IDLE. All enables, ShiftEn, Busy, BlockDone and Error are 0. NumShift, TotalCoeff, TrailingOnes, TotalZeros and the counter are 0.
- Start sampled high at edge k: TokEn=1 and Busy=1 from cycle k+1.
- A stage's Done sampled at edge n: that stage's enable drops and the next stage's enable rises in cycle n+1, with no gap cycle between stages. The shift requested in the Done cycle itself is forwarded.
- Minimum block (TotalCoeff=0, TokDone in first TOKEN cycle): Start@0, TOKEN@1, DONE@2, IDLE@3.
- Done and watchdog expiry in the same cycle: the Done transition wins and Error stays 0.
- nReset asserted mid-block: everything returns to reset values immediately. No BlockDone is produced.

## Test plan
- TotalCoeff=0: Start, TokDone in cycle 1 with TokTotalCoeff=0 -> BlockDone in cycle 2; LvlEn never high; TotalZeros=0.
- Full path: MaxNumCoeff=16, TotalCoeff=5, TotalZeros=3 -> TOKEN, LEVEL, ZEROS, RUN each entered the cycle after the prior Done; NumShift equals the enabled stage's amount every cycle.
- Skip ZEROS: MaxNumCoeff=16, TokTotalCoeff=16 -> LEVEL goes to DONE; TzEn never high; TotalZeros=0.
- Skip RUN: TotalCoeff=1, TzTotalZeros=7 -> ZEROS goes to DONE; RbEn never high; TotalZeros=7. Separately, TotalCoeff=4 with TzTotalZeros=0 -> DONE.
- Watchdog: TIMEOUT=20, LvlDone held low -> Error and BlockDone pulse together 21 cycles after the first TOKEN cycle; then IDLE.
- Robustness: Start pulsed in LEVEL -> ignored. TzShiftEn=1 during LEVEL -> not forwarded. nReset low in RUN -> all outputs 0 and IDLE next cycle.
